// File: rtl/uart_loader.sv
// Wishbone master that configures the UART, polls received bytes, packs them
// little-endian into 32-bit words and hands them downstream over valid/ready.
module uart_loader #(
  parameter logic [15:0] DIV_VALUE     = 16'd85,
  parameter logic [23:0] TIMEOUT_POLLS = 24'd0
) (
  input  logic        CLK_I,
  input  logic        RST_I,
  input  logic        start,
  input  logic [15:0] n_words,
  output logic        CYC_O,
  output logic        STB_O,
  output logic        WE_O,
  output logic [2:0]  ADR_O,
  output logic [31:0] DAT_O,
  input  logic [31:0] DAT_I,
  input  logic        ACK_I,
  output logic        word_valid,
  output logic [31:0] word_data,
  output logic [15:0] word_index,
  input  logic        word_ready,
  output logic        busy,
  output logic        done,
  output logic        error
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CFGDIV = 3'd1;
  localparam logic [2:0] S_CFGRX  = 3'd2;
  localparam logic [2:0] S_POLL   = 3'd3;
  localparam logic [2:0] S_EMIT   = 3'd4;
  localparam logic [2:0] S_RXOFF  = 3'd5;
  localparam logic [2:0] S_DONE   = 3'd6;

  logic [2:0]  state;
  logic [15:0] nw;
  logic [1:0]  bcnt;
  logic [23:0] tcnt;
  logic        unused_bits;

  assign unused_bits = &{1'b0, DAT_I[30:8]};
  assign STB_O       = CYC_O;
  assign word_valid  = (state == S_EMIT);

  // {WE, ADR, DAT} of the single transaction each bus state performs
  function automatic logic [35:0] req_of(input logic [2:0] s);
    case (s)
      S_CFGDIV: return {1'b1, 3'd6, 16'd0, DIV_VALUE};
      S_CFGRX:  return {1'b1, 3'd3, 32'd1};
      S_POLL:   return {1'b0, 3'd1, 32'd0};
      default:  return {1'b1, 3'd3, 32'd0};
    endcase
  endfunction

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state      <= S_IDLE;
      CYC_O      <= 1'b0;
      WE_O       <= 1'b0;
      ADR_O      <= 3'd0;
      DAT_O      <= 32'd0;
      word_data  <= 32'd0;
      word_index <= 16'd0;
      nw         <= 16'd0;
      bcnt       <= 2'd0;
      tcnt       <= 24'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          busy  <= 1'b1;
          error <= 1'b0;
          if (n_words != 16'd0) begin
            nw         <= n_words;
            bcnt       <= 2'd0;
            tcnt       <= 24'd0;
            word_index <= 16'd0;
            state      <= S_CFGDIV;
            CYC_O      <= 1'b1;
            {WE_O, ADR_O, DAT_O} <= req_of(S_CFGDIV);
          end else begin
            done  <= 1'b1;
            state <= S_DONE;
          end
        end
        S_CFGDIV, S_CFGRX, S_POLL, S_RXOFF: begin
          if (!CYC_O) begin
            // previous cycle had CYC_O low, which provides the inter-transaction gap
            CYC_O <= 1'b1;
            {WE_O, ADR_O, DAT_O} <= req_of(state);
          end else if (ACK_I) begin
            CYC_O <= 1'b0;
            {WE_O, ADR_O, DAT_O} <= 36'd0;
            case (state)
              S_CFGDIV: state <= S_CFGRX;
              S_CFGRX:  state <= S_POLL;
              S_POLL: begin
                if (DAT_I[31]) begin
                  tcnt <= tcnt + 24'd1;
                  if (TIMEOUT_POLLS != 24'd0 && tcnt + 24'd1 == TIMEOUT_POLLS) begin
                    error <= 1'b1;
                    state <= S_RXOFF;
                  end
                end else begin
                  tcnt <= 24'd0;
                  word_data[{bcnt, 3'b000} +: 8] <= DAT_I[7:0];
                  bcnt <= bcnt + 2'd1;
                  if (bcnt == 2'd3) state <= S_EMIT;
                end
              end
              S_RXOFF: begin
                done  <= 1'b1;
                state <= S_DONE;
              end
              default: ;
            endcase
          end
        end
        S_EMIT: if (word_ready) begin
          // the next request goes out immediately; the bus has been idle since the last ACK
          CYC_O <= 1'b1;
          if (word_index == nw - 16'd1) begin
            state <= S_RXOFF;
            {WE_O, ADR_O, DAT_O} <= req_of(S_RXOFF);
          end else begin
            word_index <= word_index + 16'd1;
            state      <= S_POLL;
            {WE_O, ADR_O, DAT_O} <= req_of(S_POLL);
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_loader.sv
// Directed bench for uart_loader: UART bus model, stalling word consumer and
// hand-computed expectations for config, load, backpressure, timeout and reset.
module tb_uart_loader;
  logic        CLK_I = 1'b0, RST_I = 1'b1, start = 1'b0;
  logic [15:0] n_words = 16'd0;
  logic [31:0] DAT_I = 32'd0;
  logic        ACK_I = 1'b0, word_ready = 1'b0;
  logic        CYC_O, STB_O, WE_O, word_valid, busy, done, error;
  logic [2:0]  ADR_O;
  logic [31:0] DAT_O, word_data;
  logic [15:0] word_index;

  always #5 CLK_I = ~CLK_I;

  uart_loader #(.DIV_VALUE(16'd85), .TIMEOUT_POLLS(24'd4)) dut (
    .CLK_I(CLK_I), .RST_I(RST_I), .start(start), .n_words(n_words),
    .CYC_O(CYC_O), .STB_O(STB_O), .WE_O(WE_O), .ADR_O(ADR_O), .DAT_O(DAT_O),
    .DAT_I(DAT_I), .ACK_I(ACK_I), .word_valid(word_valid), .word_data(word_data),
    .word_index(word_index), .word_ready(word_ready), .busy(busy), .done(done),
    .error(error)
  );

  int total = 0, bad = 0;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // UART model: acks after lat cycles, logs {WE,ADR,DAT}, serves rxq on ADR 1 reads
  logic [31:0] rxq[$];
  logic [35:0] blog[$];
  logic [35:0] snap;
  logic        in_req = 1'b0;
  int lat = 0, lcnt = 0, gap_err = 0, stab_err = 0, stall_bus = 0;

  always @(negedge CLK_I) begin
    if (RST_I) begin
      ACK_I = 1'b0; in_req = 1'b0; lcnt = 0;
    end else if (ACK_I) begin
      ACK_I = 1'b0; in_req = 1'b0;
      if (CYC_O) gap_err++;
    end else if (!(CYC_O && STB_O)) begin
      in_req = 1'b0;
    end else begin
      if (!in_req) begin
        in_req = 1'b1; snap = {WE_O, ADR_O, DAT_O}; lcnt = 0;
      end else if ({WE_O, ADR_O, DAT_O} !== snap) stab_err++;
      if (word_valid) stall_bus++;
      if (lcnt >= lat) begin
        ACK_I = 1'b1;
        blog.push_back(snap);
        if (!WE_O && ADR_O == 3'd1) begin
          if (rxq.size() != 0) DAT_I = rxq.pop_front();
          else DAT_I = 32'h8000_0077;
        end else DAT_I = 32'd0;
      end else lcnt++;
    end
  end

  // consumer: holds word_ready low for 'stall' cycles of each word
  logic [31:0] wq[$];
  logic [15:0] iq[$];
  logic [31:0] sd;
  logic [15:0] si;
  logic        seen = 1'b0, err_at_done = 1'b0;
  int stall = 0, scnt = 0, unstable = 0, dcnt = 0;

  always @(negedge CLK_I) begin
    if (done) begin dcnt++; err_at_done = error; end
    if (word_valid && !RST_I) begin
      if (!seen) begin seen = 1'b1; sd = word_data; si = word_index; scnt = 0; end
      else if (word_data !== sd || word_index !== si) unstable++;
      if (scnt >= stall) begin
        word_ready = 1'b1; wq.push_back(sd); iq.push_back(si); seen = 1'b0;
      end else begin
        word_ready = 1'b0; scnt++;
      end
    end else begin
      word_ready = 1'b0; seen = 1'b0;
    end
  end

  task automatic push_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) rxq.push_back(32'h4A3C_0000 | {24'd0, w[8*k +: 8]});
  endtask

  task automatic pulse_start(input logic [15:0] n);
    @(negedge CLK_I); n_words = n; start = 1'b1;
    @(negedge CLK_I); start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 3000; i++) begin
      if (done) break;
      @(negedge CLK_I);
    end
    chk(tag, done, 1);
    repeat (2) @(negedge CLK_I);
  endtask

  task automatic wait_poll(input string tag);
    for (int i = 0; i < 200; i++) begin
      if (CYC_O && ADR_O == 3'd1) break;
      @(negedge CLK_I);
    end
    chk(tag, CYC_O && ADR_O == 3'd1, 1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ctl"}, {CYC_O, STB_O, WE_O, ADR_O, word_valid, busy, done, error}, 0);
    chk({tag, "_dat"}, DAT_O, 0);
    chk({tag, "_wdata"}, word_data, 0);
    chk({tag, "_widx"}, word_index, 0);
  endtask

  task automatic clear_logs();
    blog.delete(); wq.delete(); iq.delete(); dcnt = 0;
  endtask

  initial begin
    // reset, then idle
    repeat (3) @(negedge CLK_I);
    RST_I = 1'b0;
    repeat (10) @(negedge CLK_I);
    chk_all_zero("idle");
    chk("idle_bus", blog.size(), 0);

    // config sequence plus one-word load
    clear_logs(); lat = 1; stall = 0;
    rxq.push_back(32'h8000_0000); rxq.push_back(32'hFFFF_FFFF);
    push_word(32'hDEADBEEF);
    pulse_start(16'd1);
    chk("start_busy", busy, 1);
    chk("start_cyc", CYC_O, 1);
    wait_done("w1_done");
    chk("w1_nbus", blog.size(), 9);
    chk("w1_cfgdiv", blog[0], {1'b1, 3'd6, 32'h0000_0055});
    chk("w1_cfgrx", blog[1], {1'b1, 3'd3, 32'h1});
    chk("w1_poll", blog[2], {1'b0, 3'd1, 32'h0});
    chk("w1_rxoff", blog[8], {1'b1, 3'd3, 32'h0});
    chk("w1_nword", wq.size(), 1);
    chk("w1_data", wq[0], 32'hDEADBEEF);
    chk("w1_idx", iq[0], 0);
    chk("w1_dcnt", dcnt, 1);
    chk("w1_err", err_at_done, 0);
    chk("w1_busy", busy, 0);

    // backpressure, zero-wait ACK
    clear_logs(); lat = 0; stall = 5;
    push_word(32'h11223344); rxq.push_back(32'h8000_0000);
    push_word(32'hCAFEF00D); rxq.push_back(32'h8000_0000); rxq.push_back(32'h8000_0000);
    push_word(32'h0BADC0DE);
    pulse_start(16'd3);
    wait_done("bp_done");
    chk("bp_nword", wq.size(), 3);
    chk("bp_d0", wq[0], 32'h11223344);
    chk("bp_d1", wq[1], 32'hCAFEF00D);
    chk("bp_d2", wq[2], 32'h0BADC0DE);
    chk("bp_idx", {iq[0], iq[1], iq[2]}, {16'd0, 16'd1, 16'd2});
    chk("bp_nbus", blog.size(), 18);
    chk("bp_rxoff", blog[17], {1'b1, 3'd3, 32'h0});
    chk("bp_dcnt", dcnt, 1);

    // timeout after four empty polls
    clear_logs(); lat = 1; stall = 0;
    pulse_start(16'd2);
    wait_done("to_done");
    chk("to_nbus", blog.size(), 7);
    chk("to_poll4", blog[5], {1'b0, 3'd1, 32'h0});
    chk("to_rxoff", blog[6], {1'b1, 3'd3, 32'h0});
    chk("to_err", err_at_done, 1);
    chk("to_err_hold", error, 1);
    chk("to_nword", wq.size(), 0);

    // zero-word request
    clear_logs();
    pulse_start(16'd0);
    chk("nw0_done", done, 1);
    repeat (3) @(negedge CLK_I);
    chk("nw0_bus", blog.size(), 0);
    chk("nw0_busy", busy, 0);
    chk("nw0_dcnt", dcnt, 1);

    // start while busy is ignored; reset mid-poll; fresh restart
    clear_logs(); lat = 2;
    pulse_start(16'd2);
    wait_poll("mr_poll1");
    pulse_start(16'd0);
    chk("mr_ign_done", done, 0);
    chk("mr_ign_busy", busy, 1);
    wait_poll("mr_poll2");
    RST_I = 1'b1;
    @(negedge CLK_I);
    chk_all_zero("mr_rst");
    RST_I = 1'b0;
    clear_logs(); lat = 0;
    push_word(32'h01234567);
    pulse_start(16'd1);
    wait_done("mr_done");
    chk("mr_first", blog[0], {1'b1, 3'd6, 32'h0000_0055});
    chk("mr_data", wq.size() == 1 ? wq[0] : 32'hx, 32'h01234567);
    chk("mr_dcnt", dcnt, 1);

    // protocol monitors accumulated over the whole run
    chk("gap_err", gap_err, 0);
    chk("stab_err", stab_err, 0);
    chk("stall_bus", stall_bus, 0);
    chk("unstable", unstable, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end
endmodule

// File: doc/uart_loader.md
# uart_loader

Wishbone-master sequencer that owns the `uart` peripheral during boot or program download. On `start` it configures the baud divisor and receiver, then polls the receive-data register. It packs incoming bytes little-endian into 32-bit words and hands each word to a downstream memory writer over a valid/ready handshake. When the requested word count is reached, or a poll timeout expires, it disables the receiver, reports completion and releases the bus.

## Interface
- `DIV_VALUE`, 85: value written to the UART baud divisor register (ADR 6), 16 bits.
- `TIMEOUT_POLLS`, 0: number of consecutive empty polls that aborts the load; 0 disables the timeout; 24 bits.
- `CLK_I`  in  1  single clock; all state updates on the rising edge.
- `RST_I`  in  1  reset; synchronous and active-high.
- `start`  in  1  one-cycle request; ignored unless idle.
- `n_words`  in  16  number of words to load; sampled when `start` is accepted.
- `CYC_O`, `STB_O`  out  1  Wishbone cycle/strobe toward `uart`.
- `WE_O`  out  1  1 = write, 0 = read.
- `ADR_O`  out  3  UART register index.
- `DAT_O`  out  32  write data.
- `DAT_I`  in  32  UART read data.
- `ACK_I`  in  1  UART acknowledge.
- `word_valid`  out  1  `word_data`/`word_index` valid.
- `word_data`  out  32  assembled word; byte k sits at bits [8k+7:8k].
- `word_index`  out  16  word number, 0-based.
- `word_ready`  in  1  consumer accepts the word.
- `busy`  out  1  high from `start` acceptance until `done`.
- `done`  out  1  one-cycle completion pulse.
- `error`  out  1  timeout flag; valid with `done`, held until the next `start`.

## Operation
- States: Idle, CfgDiv, CfgRx, Poll, Emit, RxOff, Done.
- **Idle:**
  - `start`=1 and `n_words`≠0: latch the count, clear byte/word/timeout counters and `error`, go to CfgDiv.
  - `start`=1 and `n_words`=0: go to Done and issue no bus cycles.
- **CfgDiv:** write ADR 6, `DAT_O`={16'b0, `DIV_VALUE`}, then go to CfgRx.
- **CfgRx:** write ADR 3, `DAT_O`=32'h1 (rxen=1, rxcnt=0), then go to Poll.
- **Poll:** read ADR 1. On ACK:
  - `DAT_I[31]`=1 (FIFO empty): increment the timeout counter. If `TIMEOUT_POLLS`≠0 and the counter reaches it, set `error` and go to RxOff; otherwise poll again.
  - `DAT_I[31]`=0: clear the timeout counter and store `DAT_I[7:0]` into byte lane `byte_cnt`. `byte_cnt` is 2 bits and wraps 3→0. The byte that completes lane 3 moves the FSM to Emit; otherwise poll again.
- **Emit:** `word_valid`=1; `word_data`/`word_index` stay stable until the handshake (`word_valid & word_ready`). On handshake:
  - if `word_index`=`n_words`-1, go to RxOff;
  - else increment `word_index` and go to Poll.
  - Only bits [7:0] of each byte come from `DAT_I`; the other `DAT_I` bits are ignored.
- **RxOff:** write ADR 3, `DAT_O`=0, then go to Done.
- **Done:** `done`=1 for one cycle, `busy` falls, go to Idle.
- **Wishbone master rules:**
  - `CYC_O`=`STB_O`=1 with stable `WE_O`/`ADR_O`/`DAT_O` until ACK_I is sampled 1.
  - `CYC_O`/`STB_O` clear on that same edge.
  - At least one cycle with `CYC_O`=0 between consecutive transactions.
  - `DAT_O`=0 during reads.
- `word_index` counts modulo 2^16; `n_words`=65535 is legal.
- **`RST_I`:** returns to Idle and clears all counters and outputs on the same edge, including mid-transaction. UART registers are not restored.

## Timing
- **Reset values:** `CYC_O`, `STB_O`, `WE_O`, `ADR_O`, `DAT_O`, `word_valid`, `word_data`, `word_index`, `busy`, `done`, `error` all 0.
- `start` sampled at edge t → `busy`=1 and `CYC_O`=1 (CfgDiv write) from t+1.
- Zero-wait ACK is legal: ACK at edge a → bus idle during a+1, next request from a+2.
- 4th byte ACK at edge a → `word_valid`=1 from a+1.
- Emit handshake at edge h → next Poll request from h+1.
- ACK_I seen while `CYC_O`=0 is ignored.
- `word_ready` high outside Emit has no effect.
- **Last-word path:** handshake at h → RxOff request at h+1; RxOff ACK at r → `done`=1 during r+1 and `busy`=0 from r+2.
- `n_words`=0: `start` at t → `done` at t+1, no bus activity.

## Test plan
- Reset, then idle 10 cycles → all outputs 0, no bus cycles.
- **Config sequence:** `start`, `n_words`=1, `DIV_VALUE`=85 → writes ADR6=0x0000_0055 then ADR3=0x1, each held until ACK, with a ≥1-cycle gap.
- **One-word load:** model returns empty, empty, then bytes 0xEF, 0xBE, 0xAD, 0xDE → `word_data`=0xDEADBEEF, `word_index`=0; ADR3=0 write follows; `done` pulses once; `error`=0.
- **Backpressure:** 3 words, `word_ready` low 5 cycles per word → data/index stable while stalled, no polls during stall, indices 0,1,2.
- **Timeout:** `TIMEOUT_POLLS`=4, model always empty → exactly 4 polls, then ADR3=0 write, `done` with `error`=1.
- **Mid-transaction reset:** `RST_I` asserted while Poll `STB_O`=1 → next cycle all outputs 0. A `start` during `busy` is ignored, and a fresh `start` restarts from CfgDiv.
